seg_scan_driver: RTL and testbench

Downstream display stage for the lab adder datapath: captures an 8-bit unsigned result (e.g. zero-extended `{CO, SUM}`), converts it to three BCD digits with a sequential double-dabble engine, and time-multiplexes the four-digit common-anode seven-segment display. It replaces the static single-digit drive (`an` fixed at one digit) so values above 9 display correctly in decimal.

---
 rtl/seg_scan_driver.sv | 169 ++++++++++++++++
 tb/tb_seg_scan_driver.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Converts an 8-bit value to decimal and scans it onto a 4-digit common-anode display.
// Build option: define SEG_LZ_BLANK_EN to blank leading zeros in the hundreds and tens digits.
module seg_scan_driver #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] value,
   output logic       busy,
   output logic [6:0] seg,
   output logic [3:0] an
);

   typedef enum logic {S_IDLE, S_CONV} state_t;

   localparam int PW = $clog2(REFRESH_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

`ifdef SEG_LZ_BLANK_EN
   localparam bit LZ_BLANK = 1'b1;
`else
   localparam bit LZ_BLANK = 1'b0;
`endif

   state_t        state_q, state_d;
   logic [7:0]    bin_q, bin_d;
   logic [11:0]   bcd_q, bcd_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic [3:0]    ones_q, ones_d;
   logic [3:0]    tens_q, tens_d;
   logic [3:0]    hund_q, hund_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [1:0]    idx_q, idx_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;

   logic [11:0]   adj;
   logic [19:0]   shifted;
   logic [3:0]    digit;
   logic          digit_blank;

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Double-dabble step: correct every nibble, then shift {bcd, bin} left by one.
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      ones_d  = ones_q;
      tens_d  = tens_q;
      hund_d  = hund_q;
      adj     = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
      shifted = {adj[10:0], bin_q, 1'b0};
      case (state_q)
         S_IDLE: begin
            if (load) begin
               bin_d   = value;
               bcd_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_CONV;
            end
         end
         S_CONV: begin
            bcd_d = shifted[19:8];
            bin_d = shifted[7:0];
            cnt_d = cnt_q + 3'd1;
            // Eighth shift: commit all three digits together so no partial value is shown.
            if (cnt_q == 3'd7) begin
               hund_d  = shifted[19:16];
               tens_d  = shifted[15:12];
               ones_d  = shifted[11:8];
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      presc_d = presc_q + PW'(1);
      idx_d   = idx_q;
      if (presc_q == PRESC_LAST) begin
         presc_d = '0;
         idx_d   = idx_q + 2'd1;
      end
   end

   // Outputs are built from the current index so each slot lasts exactly REFRESH_DIV cycles.
   always_comb begin
      digit       = ones_q;
      digit_blank = 1'b0;
      case (idx_q)
         2'd0: digit = ones_q;
         2'd1: begin
            digit       = tens_q;
            digit_blank = LZ_BLANK && (hund_q == 4'd0) && (tens_q == 4'd0);
         end
         2'd2: begin
            digit       = hund_q;
            digit_blank = LZ_BLANK && (hund_q == 4'd0);
         end
         default: digit_blank = 1'b1;
      endcase
      seg_d = digit_blank ? SEG_BLANK : seg_of(digit);
      an_d  = ~(4'b0001 << idx_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         ones_q  <= '0;
         tens_q  <= '0;
         hund_q  <= '0;
         presc_q <= '0;
         idx_q   <= '0;
         an_q    <= 4'b1111;
         seg_q   <= SEG_BLANK;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         ones_q  <= ones_d;
         tens_q  <= tens_d;
         hund_q  <= hund_d;
         presc_q <= presc_d;
         idx_q   <= idx_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
      end
   end

   assign busy = busy_q;
   assign seg  = seg_q;
   assign an   = an_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed scenarios plus random loads against a decimal-arithmetic model.
module tb_seg_scan_driver;
   localparam int DIV = 4;

`ifdef SEG_LZ_BLANK_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       load = 1'b0;
   logic [7:0] value = 8'd0;
   logic       busy;
   logic [6:0] seg;
   logic [3:0] an;

   seg_scan_driver #(.REFRESH_DIV(DIV)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .value (value),
      .busy  (busy),
      .seg   (seg),
      .an    (an)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference state: edges since reset release, remaining busy cycles, pending and shown values.
   int edge_k    = 0;
   int busy_left = 0;
   int pend_val  = 0;
   int disp_val  = 0;

   logic [6:0] seg_lut [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] exp_digit(input int idx, input int v);
      int h, t, o;
      h = v / 100;
      t = (v / 10) % 10;
      o = v % 10;
      case (idx)
         0: return seg_lut[o];
         1: return (LZ && h == 0 && t == 0) ? 7'b1111111 : seg_lut[t];
         2: return (LZ && h == 0) ? 7'b1111111 : seg_lut[h];
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic tick(input string tag);
      int         idx;
      logic [3:0] one;
      logic [3:0] exp_an;
      logic [6:0] exp_seg;
      one = 4'b0001;
      @(posedge clk);
      edge_k++;
      idx     = ((edge_k - 1) / DIV) % 4;
      exp_an  = ~(one << idx);
      exp_seg = exp_digit(idx, disp_val);
      if (busy_left > 0) begin
         busy_left--;
         if (busy_left == 0) disp_val = pend_val;
      end else if (load) begin
         pend_val  = value;
         busy_left = 8;
      end
      @(negedge clk);
      check({tag, "_busy"}, 32'(busy), 32'(busy_left > 0));
      check({tag, "_an"}, 32'(an), 32'(exp_an));
      check({tag, "_seg"}, 32'(seg), 32'(exp_seg));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_an"}, 32'(an), 32'hF);
      check({tag, "_seg"}, 32'(seg), 32'h7F);
   endtask

   // Asserted away from the rising edge; outputs must clear at once, not at the next clock.
   task automatic do_reset(input string tag, input int cycles);
      rst_n = 1'b0;
      load  = 1'b0;
      #1;
      check_reset_outputs({tag, "_now"});
      repeat (cycles) @(negedge clk);
      check_reset_outputs({tag, "_held"});
      edge_k    = 0;
      busy_left = 0;
      disp_val  = 0;
      rst_n     = 1'b1;
   endtask

   task automatic send(input string tag, input logic [7:0] v);
      load  = 1'b1;
      value = v;
      tick(tag);
      load  = 1'b0;
   endtask

   task automatic run(input string tag, input int n);
      repeat (n) tick(tag);
   endtask

   initial begin
      #2;
      do_reset("rst", 3);
      run("scan", 20);

      send("ld255", 8'd255);
      run("c255", 24);

      send("ld19", 8'd19);
      run("c19", 24);

      // Second load mid-conversion is dropped; a load right after completion is taken.
      send("ld255b", 8'd255);
      for (int i = 1; i <= 8; i++) begin
         if (i == 4) begin
            load  = 1'b1;
            value = 8'd3;
         end
         tick("drop");
         load = 1'b0;
      end
      send("ld3", 8'd3);
      run("c3", 24);

      send("ld128", 8'd128);
      run("c128", 4);
      do_reset("midrst", 2);
      run("post", 20);

      send("ld100", 8'd100);
      run("frames", 8 + 3 * 4 * DIV);

      for (int i = 0; i < 1500; i++) begin
         load  = ($urandom_range(0, 7) == 0);
         value = 8'($urandom_range(0, 255));
         tick("rnd");
      end
      load = 1'b0;
      run("tail", 20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
